// File: rtl/iob_cpu_bus_arbiter.sv
// Two-master, one-slave arbiter for the native iob bus: the CPU instruction bus (m0)
// and data bus (m1) share one slave port, one transaction at a time.
module iob_cpu_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_ready,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_ready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_address,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state_r;
  logic [0:0] state_nxt_s;
  logic       grant_r;
  logic       grant_nxt_s;
  logic       last_grant_r;
  logic       busy_s;
  logic       done_s;
  logic       wd_expire_s;

  assign busy_s = (state_r == BUSY);
  // A transaction ends on the slave strobe or, failing that, on watchdog expiry.
  assign done_s = busy_s && (s_ready || wd_expire_s);

  // Arbitration decision; only consumed on the IDLE->BUSY transition
  always_comb begin
    grant_nxt_s = grant_r;
    if (m0_valid && m1_valid) begin
      if (ARB_MODE == 1) begin
        grant_nxt_s = 1'b1;
      end else begin
        grant_nxt_s = ~last_grant_r;
      end
    end else if (m1_valid) begin
      grant_nxt_s = 1'b1;
    end else if (m0_valid) begin
      grant_nxt_s = 1'b0;
    end else begin
      grant_nxt_s = grant_r;
    end
  end

  // Next-state logic of the IDLE/BUSY controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant and round-robin history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s == BUSY)) begin
        grant_r <= grant_nxt_s;
      end
      if (done_s) begin
        last_grant_r <= grant_r;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_r;
      logic             err_r;

      assign wd_expire_s = busy_s && !s_ready && (cnt_r == CNT_LAST);
      assign timeout_err = err_r;

      // Stall counter: held at zero in IDLE so every BUSY period starts fresh
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_r <= '0;
        end else if (!busy_s) begin
          cnt_r <= '0;
        end else if (!s_ready && !wd_expire_s) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end

      // Sticky error flag, cleared only by reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          err_r <= 1'b0;
        end else if (wd_expire_s) begin
          err_r <= 1'b1;
        end
      end
    end else begin : g_no_wdog
      assign wd_expire_s = 1'b0;
      assign timeout_err = 1'b0;
    end
  endgenerate

  // Request routing: only the granted master reaches the slave, and only in BUSY
  always_comb begin
    s_valid   = busy_s;
    s_address = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    if (busy_s) begin
      if (grant_r) begin
        s_address = m1_address;
        s_wdata   = m1_wdata;
        s_wstrb   = m1_wstrb;
      end else begin
        s_address = m0_address;
        s_wdata   = m0_wdata;
        s_wstrb   = m0_wstrb;
      end
    end else begin
      s_address = '0;
      s_wdata   = '0;
      s_wstrb   = '0;
    end
  end

  // Response routing; a forced completion returns zero data
  always_comb begin
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (done_s) begin
      if (grant_r) begin
        m1_ready = 1'b1;
        m1_rdata = s_ready ? s_rdata : '0;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = s_ready ? s_rdata : '0;
      end
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// Randomized scoreboard bench: instance 0 is round-robin with an 8-cycle watchdog,
// instance 1 is fixed priority to dbus without watchdog.
module tb_iob_cpu_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int NTX = 40;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    int            done_cyc;
    bit            to;
  } txn_t;

  logic clk = 1'b0;
  logic rst;

  logic          mv  [2][2];
  logic [AW-1:0] ma  [2][2];
  logic [DW-1:0] mw  [2][2];
  logic [SW-1:0] ms  [2][2];
  logic          mr  [2][2];
  logic [DW-1:0] mrd [2][2];
  logic          sv  [2];
  logic [AW-1:0] sa  [2];
  logic [DW-1:0] swd [2];
  logic [SW-1:0] sst [2];
  logic          sr  [2];
  logic [DW-1:0] srd [2];
  logic          terr[2];

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   go       = 1'b0;
  bit   stop     = 1'b0;
  int   issued[2][2];
  txn_t exp_q[4][$];

  always #5 clk = ~clk;

  iob_cpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_valid(mv[0][0]), .m0_address(ma[0][0]), .m0_wdata(mw[0][0]), .m0_wstrb(ms[0][0]),
    .m0_ready(mr[0][0]), .m0_rdata(mrd[0][0]),
    .m1_valid(mv[0][1]), .m1_address(ma[0][1]), .m1_wdata(mw[0][1]), .m1_wstrb(ms[0][1]),
    .m1_ready(mr[0][1]), .m1_rdata(mrd[0][1]),
    .s_valid(sv[0]), .s_address(sa[0]), .s_wdata(swd[0]), .s_wstrb(sst[0]),
    .s_ready(sr[0]), .s_rdata(srd[0]), .timeout_err(terr[0])
  );

  iob_cpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_valid(mv[1][0]), .m0_address(ma[1][0]), .m0_wdata(mw[1][0]), .m0_wstrb(ms[1][0]),
    .m0_ready(mr[1][0]), .m0_rdata(mrd[1][0]),
    .m1_valid(mv[1][1]), .m1_address(ma[1][1]), .m1_wdata(mw[1][1]), .m1_wstrb(ms[1][1]),
    .m1_ready(mr[1][1]), .m1_rdata(mrd[1][1]),
    .s_valid(sv[1]), .s_address(sa[1]), .s_wdata(swd[1]), .s_wstrb(sst[1]),
    .s_ready(sr[1]), .s_rdata(srd[1]), .timeout_err(terr[1])
  );

  function automatic int tmo(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit all_done();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (issued[i][j] < NTX || exp_q[2*i+j].size() != 0 || mv[i][j]) return 1'b0;
    return 1'b1;
  endfunction

  // Builds one request; address low nibble tells the slave model its latency.
  task automatic issue(input int i, input int j);
    txn_t t;
    int r;
    logic [3:0] code;
    r = int'($urandom_range(0, 15));
    if (r < 10)      code = 4'(r % 4);
    else if (r < 12) code = 4'd7;
    else             code = (i == 0) ? 4'(8 + r % 8) : 4'(r % 8);
    t.addr  = ($urandom & 32'hFFFF_FFF0) | {28'd0, code};
    t.wdata = $urandom;
    t.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    if (issued[i][j] == 0 && i == 0 && j == 0) begin
      t.addr  = 32'h0000_0102;
      t.wstrb = 4'h0;
    end
    if (issued[i][j] == 0 && i == 1 && j == 1) begin
      t.addr  = 32'h0000_0020;
      t.wdata = 32'h1234_5678;
      t.wstrb = 4'hF;
    end
    code       = t.addr[3:0];
    t.to       = (code >= 4'd8);
    t.done_cyc = t.to ? tmo(i) : int'(code) + 1;
    t.rdata    = t.to ? 32'h0 : slave_data(t.addr);
    exp_q[2*i+j].push_back(t);
    mv[i][j] = 1'b1;
    ma[i][j] = t.addr;
    mw[i][j] = t.wdata;
    ms[i][j] = t.wstrb;
    issued[i][j]++;
  endtask

  // Slave model: answers after addr[3:0] BUSY cycles, never for codes >= 8,
  // and throws stray ready pulses while no request is presented.
  initial begin : slave
    int scnt[2];
    bit sv_prev[2];
    logic [3:0] code;
    for (int i = 0; i < 2; i++) begin
      sr[i] = 1'b0; srd[i] = '0; scnt[i] = 0; sv_prev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (sv[i] === 1'b1) begin
          scnt[i] = sv_prev[i] ? scnt[i] + 1 : 0;
          code    = sa[i][3:0];
          sr[i]   = (code < 4'd8) && (scnt[i] == int'(code));
          srd[i]  = sr[i] ? slave_data(sa[i]) : $urandom;
          sv_prev[i] = 1'b1;
        end else begin
          sr[i]  = ($urandom_range(0, 3) == 0);
          srd[i] = $urandom;
          sv_prev[i] = 1'b0;
        end
      end
    end
  end

  // Master drivers: hold each request until its ready, then random gap or back-to-back.
  initial begin : driver
    int gap[2][2];
    bit rdy_seen[2][2];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        gap[i][j] = 0; rdy_seen[i][j] = 1'b0;
      end
    wait (go);
    while (!stop) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          if (mv[i][j] && rdy_seen[i][j]) begin
            mv[i][j]  = 1'b0;
            gap[i][j] = int'($urandom_range(0, 2));
          end
          if (!mv[i][j] && issued[i][j] < NTX) begin
            if (gap[i][j] == 0) issue(i, j);
            else gap[i][j]--;
          end
        end
      #2;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) rdy_seen[i][j] = (mr[i][j] === 1'b1);
    end
  end

  // Monitor: transaction-level reference of who is served when, checked every cycle.
  initial begin : monitor
    bit   m_busy[2];
    bit   m_done[2];
    bit   pv[2][2];
    bit   exp_err[2];
    int   cur[2];
    int   last[2];
    int   cyc[2];
    int   k;
    int   o;
    bit   dn;
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; exp_err[i] = 1'b0;
      cur[i] = 0; last[i] = 1; cyc[i] = 0; pv[i][0] = 1'b0; pv[i][1] = 1'b0;
    end
    wait (go);
    while (!stop) begin
      @(negedge clk);
      #3;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i] && m_done[i]) begin
          m_busy[i] = 1'b0;
        end else if (!m_busy[i] && (pv[i][0] || pv[i][1])) begin
          m_busy[i] = 1'b1;
          cyc[i]    = 0;
          if (pv[i][0] && pv[i][1]) cur[i] = (i == 1) ? 1 : 1 - last[i];
          else                      cur[i] = pv[i][1] ? 1 : 0;
        end
        m_done[i] = 1'b0;
        check($sformatf("s_valid[%0d]", i), {31'd0, sv[i]}, {31'd0, m_busy[i]});
        if (m_busy[i]) begin
          cyc[i]++;
          k = 2 * i + cur[i];
          o = 1 - cur[i];
          if (exp_q[k].size() == 0) begin
            n_checks++;
            $display("FAIL grant[%0d]: master %0d granted with no pending request, expected a pending one", i, cur[i]);
            m_busy[i] = 1'b0;
          end else begin
            t  = exp_q[k][0];
            dn = (cyc[i] == t.done_cyc);
            check($sformatf("s_address[%0d]", i), sa[i], t.addr);
            check($sformatf("s_wdata[%0d]", i), swd[i], t.wdata);
            check($sformatf("s_wstrb[%0d]", i), {28'd0, sst[i]}, {28'd0, t.wstrb});
            check($sformatf("ready_granted[%0d]", i), {31'd0, mr[i][cur[i]]}, {31'd0, dn});
            check($sformatf("ready_other[%0d]", i), {31'd0, mr[i][o]}, 32'd0);
            check($sformatf("rdata_other[%0d]", i), mrd[i][o], 32'd0);
            if (dn) begin
              check($sformatf("rdata_granted[%0d]", i), mrd[i][cur[i]], t.rdata);
              check($sformatf("timeout_err[%0d]", i), {31'd0, terr[i]}, {31'd0, exp_err[i]});
              exp_err[i] = exp_err[i] | t.to;
              void'(exp_q[k].pop_front());
              m_done[i] = 1'b1;
              last[i]   = cur[i];
            end
          end
        end else begin
          check($sformatf("ready_idle[%0d]", i), {30'd0, mr[i][1], mr[i][0]}, 32'd0);
          check($sformatf("timeout_err[%0d]", i), {31'd0, terr[i]}, {31'd0, exp_err[i]});
        end
        pv[i][0] = (mv[i][0] === 1'b1);
        pv[i][1] = (mv[i][1] === 1'b1);
      end
    end
  end

  initial begin : main
    bit drained;
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        mv[i][j] = 1'b0; ma[i][j] = '0; mw[i][j] = '0; ms[i][j] = '0; issued[i][j] = 0;
      end
    repeat (3) @(negedge clk);
    #3;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_s_valid[%0d]", i), {31'd0, sv[i]}, 32'd0);
      check($sformatf("rst_s_address[%0d]", i), sa[i], 32'd0);
      check($sformatf("rst_ready[%0d]", i), {30'd0, mr[i][1], mr[i][0]}, 32'd0);
      check($sformatf("rst_timeout_err[%0d]", i), {31'd0, terr[i]}, 32'd0);
    end
    rst = 1'b0;
    go  = 1'b1;

    drained = 1'b0;
    for (int c = 0; c < 20000 && !drained; c++) begin
      @(negedge clk);
      #4;
      drained = all_done();
    end
    if (!drained) begin
      n_checks++;
      $display("FAIL drain: transactions still outstanding after 20000 cycles, expected all completed");
    end
    stop = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted between clock edges while instance 0 is BUSY on a never-answered request.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) mv[i][j] = 1'b0;
    repeat (2) @(negedge clk);
    mv[0][0] = 1'b1;
    ma[0][0] = 32'h0000_010F;
    mw[0][0] = 32'hA5A5_A5A5;
    ms[0][0] = 4'h3;
    for (int c = 0; c < 10 && sv[0] !== 1'b1; c++) @(negedge clk);
    check("busy_before_rst", {31'd0, sv[0]}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    mv[0][0] = 1'b0;
    #1;
    check("midrst_s_valid", {31'd0, sv[0]}, 32'd0);
    check("midrst_s_address", sa[0], 32'd0);
    check("midrst_s_wdata", swd[0], 32'd0);
    check("midrst_s_wstrb", {28'd0, sst[0]}, 32'd0);
    check("midrst_ready", {30'd0, mr[0][1], mr[0][0]}, 32'd0);
    check("midrst_rdata0", mrd[0][0], 32'd0);
    check("midrst_rdata1", mrd[0][1], 32'd0);
    check("midrst_timeout_err", {31'd0, terr[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #3;
      check("post_rst_s_valid", {31'd0, sv[0]}, 32'd0);
      check("post_rst_ready", {30'd0, mr[0][1], mr[0][0]}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
